dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the MEM stage of the 5-stage MIPS pipeline.
- Accepts a single load or store request from the pipeline and serves it with a fixed, parameterised latency.
- Holds the pipeline with Stall until the access completes.
- Handles word, half and byte lanes for lw/lh/lb/sw/sh/sb; the pipeline's WB stage performs sign extension.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words of storage (power of two).
LATENCY, 2, wait cycles after acceptance before completion (range 1..15).

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
MemRead  input  1  load request from MEM stage
MemWrite  input  1  store request from MEM stage
Size  input  2  00 word, 01 half, 10 byte, 11 treated as word
Address  input  32  byte address (ALU result)
WriteData  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
ReadData  output  32  load data, right-aligned, upper bits zero
Ready  output  1  one-cycle completion pulse
Stall  output  1  hold the pipeline (PC, IF/ID, ID/EX, EX/MEM)
MisalignErr  output  1  one-cycle pulse with Ready on a rejected access

Behaviour:
- Reset values: state IDLE, counter 0, ReadData 0, Ready 0, MisalignErr 0. Stall is 0 under reset.
- Reset does not clear storage contents. Reset during BUSY drops the captured request; a pending store is never committed.

State machine, states IDLE, BUSY, DONE:
- IDLE: a request is MemRead or MemWrite high.
  - On a request, capture Address, Size, WriteData and the direction (write has priority if both are high).
  - Load counter with LATENCY-1 and go to BUSY.
  - Stall = request (combinational).
- BUSY: Stall = 1.
  - Counter decrements each cycle.
  - At counter 0, perform the access and go to DONE.
- DONE: Ready = 1 and Stall = 0 for exactly one cycle; return to IDLE.
  - The pipeline advances on this edge.
  - A new request is seen on the following IDLE cycle.
- Timing: for an accepted request, Stall is high for exactly LATENCY+1 consecutive cycles, and Ready is high on the next cycle.

Request handling:
- Captured fields are used for the whole access. Input changes or deassertion while BUSY are ignored.

Addressing:
- Word index = Address[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Byte lanes are little-endian. The byte lane is Address[1:0]; the half lane is Address[1].

Stores:
- sw replaces the whole word.
- sh replaces bytes 2*A1 and 2*A1+1 with WriteData[15:0].
- sb replaces only byte Address[1:0] with WriteData[7:0].
- All other bytes are unchanged.
- The store commits on the BUSY→DONE edge.

Loads:
- ReadData is registered and updated on the BUSY→DONE edge. It holds its value until the next completed load.
- Word: full word. Half: selected half in [15:0]. Byte: selected byte in [7:0]. Upper bits are zero.
- Store completions leave ReadData unchanged.

Alignment:
- A half with Address[0]=1, or a word with Address[1:0]≠0, is misaligned.
- A misaligned access still uses full latency, performs no memory access, and sets ReadData to 0.
- MisalignErr pulses together with Ready.

Optional Feature:
- Macro DMEM_ACCESS_COUNT_EN.
- When defined:
  - Adds outputs LoadCount[15:0] and StoreCount[15:0].
  - Each increments on DONE for a completed aligned load or store respectively.
  - Both saturate at 0xFFFF and reset to 0.
  - Misaligned accesses are not counted.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
1. Reset, then sw 0xDEADBEEF to 0x10 and lw 0x10 → each request holds Stall high for 3 cycles followed by a Ready pulse; the load gives ReadData=0xDEADBEEF, MisalignErr=0.
2. After test 1, sb WriteData=0x000000A5 to 0x11, then lw 0x10 → ReadData=0xDEADA5EF.
3. After test 2, lh 0x12 → 0x0000DEAD; lb 0x13 → 0x000000DE; sh 0x1234 to 0x10, then lw 0x10 → 0xDEAD1234.
4. lw 0x13 and sh to 0x11 → MisalignErr pulses with Ready for each, ReadData=0, and word 0x10 is unchanged.
5. sw 0x11111111 to 0x20, Reset asserted during BUSY, then lw 0x20 → ReadData = prior contents; after reset Stall=0, Ready=0, and state is IDLE.
6. sw 0xCAFEF00D to address DEPTH_WORDS*4, then lw 0x0 → 0xCAFEF00D (wrap). With DMEM_ACCESS_COUNT_EN defined, tests 1–3 give LoadCount=5, StoreCount=3.

Source files
------------

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM-stage request/response bundle for the data-memory responder.
// LoadCount/StoreCount exist only when DMEM_ACCESS_COUNT_EN is defined.
interface dmem_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  Size;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Ready;
    logic        Stall;
    logic        MisalignErr;
`ifdef DMEM_ACCESS_COUNT_EN
    logic [15:0] LoadCount;
    logic [15:0] StoreCount;
    modport slave (input MemRead, MemWrite, Size, Address, WriteData,
                   output ReadData, Ready, Stall, MisalignErr, LoadCount, StoreCount);
    modport master (output MemRead, MemWrite, Size, Address, WriteData,
                    input ReadData, Ready, Stall, MisalignErr, LoadCount, StoreCount);
`else
    modport slave (input MemRead, MemWrite, Size, Address, WriteData,
                   output ReadData, Ready, Stall, MisalignErr);
    modport master (output MemRead, MemWrite, Size, Address, WriteData,
                    input ReadData, Ready, Stall, MisalignErr);
`endif
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data memory for the MEM stage with byte/half/word lanes.
// Optional DMEM_ACCESS_COUNT_EN adds saturating load/store completion counters.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    dmem_responder_if.slave   bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [AW+1:0] addr_q;
    logic [1:0]    size_q;
    logic [31:0]   wdata_q;
    logic          wr_q;
    logic [31:0]   rdata_q;
    logic          ready_q;
    logic          merr_q;
    logic [31:0]   mem_q [DEPTH_WORDS];
    logic          req;
    logic          mis;
    logic          last;
    logic [4:0]    sh;
    logic [31:0]   base;
    logic [31:0]   mask;
    logic [31:0]   cur;
    logic [31:0]   merged;
    logic [31:0]   rd_val;
    logic          unused_addr;
    assign unused_addr = ^bus.Address[31:AW+2];
    assign req  = bus.MemRead | bus.MemWrite;
    assign last = (state_q == BUSY) && (cnt_q == 4'd0);
    // Size 11 behaves as a word, so only 01 and 10 narrow the lane.
    always_comb begin
        mis    = size_q == 2'b10 ? 1'b0 : size_q == 2'b01 ? addr_q[0] : |addr_q[1:0];
        sh     = {addr_q[1:0], 3'b000};
        base   = size_q == 2'b10 ? 32'h0000_00FF : size_q == 2'b01 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        mask   = base << sh;
        cur    = mem_q[addr_q[AW+1:2]];
        merged = (cur & ~mask) | ((wdata_q << sh) & mask);
        rd_val = (cur >> sh) & base;
    end
    always_ff @(posedge Clk)
        if (last && wr_q && !mis) mem_q[addr_q[AW+1:2]] <= merged;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            size_q  <= 2'b00;
            wdata_q <= 32'd0;
            wr_q    <= 1'b0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            merr_q  <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            merr_q  <= 1'b0;
            case (state_q)
                IDLE: if (req) begin
                    state_q <= BUSY;
                    cnt_q   <= 4'(LATENCY - 1);
                    addr_q  <= bus.Address[AW+1:0];
                    size_q  <= bus.Size;
                    wdata_q <= bus.WriteData;
                    wr_q    <= bus.MemWrite;
                end
                BUSY: if (cnt_q == 4'd0) begin
                    state_q <= DONE;
                    ready_q <= 1'b1;
                    merr_q  <= mis;
                    if (mis) rdata_q <= 32'd0;
                    else if (!wr_q) rdata_q <= rd_val;
                end else cnt_q <= cnt_q - 4'd1;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.Stall       = !Reset && ((state_q == IDLE && req) || state_q == BUSY);
    assign bus.Ready       = ready_q;
    assign bus.MisalignErr = merr_q;
    assign bus.ReadData    = rdata_q;
`ifdef DMEM_ACCESS_COUNT_EN
    logic [15:0] ld_cnt_q;
    logic [15:0] st_cnt_q;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ld_cnt_q <= 16'd0;
            st_cnt_q <= 16'd0;
        end else if (last && !mis) begin
            if (!wr_q && ld_cnt_q != 16'hFFFF) ld_cnt_q <= ld_cnt_q + 16'd1;
            if (wr_q && st_cnt_q != 16'hFFFF) st_cnt_q <= st_cnt_q + 16'd1;
        end
    end
    assign bus.LoadCount  = ld_cnt_q;
    assign bus.StoreCount = st_cnt_q;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed per-scenario checks of the data-memory responder.
// Define DMEM_ACCESS_COUNT_EN to also check the access counters.
module tb_dmem_responder;
    logic Clk;
    logic Reset;
    int checks;
    int failures;
    dmem_responder_if bus();
    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Issues one request and follows it to its Ready pulse; inputs are scrambled once accepted.
    task automatic access(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic me, output int stalls, output logic rdy_ok);
        stalls = 0;
        rdy_ok = 1'b0;
        rd = 32'd0;
        me = 1'b0;
        @(negedge Clk);
        bus.MemWrite = wr;
        bus.MemRead = !wr;
        bus.Size = sz;
        bus.Address = a;
        bus.WriteData = wd;
        #1 if (bus.Stall) stalls++;
        @(posedge Clk);
        #1;
        bus.MemRead = 1'b0;
        bus.MemWrite = 1'b0;
        bus.Size = ~sz;
        bus.Address = ~a;
        bus.WriteData = ~wd;
        for (int n = 0; n < 40; n++) begin
            @(negedge Clk);
            if (bus.Ready) break;
            if (bus.Stall) stalls++;
        end
        rd = bus.ReadData;
        me = bus.MisalignErr;
        rdy_ok = bus.Ready && !bus.Stall;
        @(negedge Clk);
        if (bus.Ready || bus.MisalignErr) rdy_ok = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        bus.MemRead = 1'b1;
        bus.MemWrite = 1'b0;
        bus.Size = 2'b00;
        bus.Address = 32'h0;
        bus.WriteData = 32'h0;
        repeat (3) @(posedge Clk);
        #1;
        checks++; if (bus.Stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.Stall); end
        checks++; if (bus.Ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.Ready); end
        checks++; if (bus.ReadData !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=00000000", bus.ReadData); end
        checks++; if (bus.MisalignErr !== 1'b0) begin failures++; $display("FAIL reset_merr got=%b exp=0", bus.MisalignErr); end
        bus.MemRead = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_word;
        logic [31:0] rd; logic me; int st; logic ok;
        access(1'b1, 2'b00, 32'h10, 32'hDEADBEEF, rd, me, st, ok);
        checks++; if (st != 3) begin failures++; $display("FAIL sw_stall_cycles got=%0d exp=3", st); end
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL sw_ready_pulse got=%b exp=1", ok); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL sw_rdata_kept got=%h exp=00000000", rd); end
        access(1'b0, 2'b00, 32'h10, 32'h0, rd, me, st, ok);
        checks++; if (st != 3) begin failures++; $display("FAIL lw_stall_cycles got=%0d exp=3", st); end
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL lw_ready_pulse got=%b exp=1", ok); end
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data got=%h exp=deadbeef", rd); end
        checks++; if (me !== 1'b0) begin failures++; $display("FAIL lw_merr got=%b exp=0", me); end
    endtask

    task automatic test_lanes;
        logic [31:0] rd; logic me; int st; logic ok;
        access(1'b1, 2'b10, 32'h11, 32'h000000A5, rd, me, st, ok);
        access(1'b0, 2'b00, 32'h10, 32'h0, rd, me, st, ok);
        checks++; if (rd !== 32'hDEADA5EF) begin failures++; $display("FAIL sb_then_lw got=%h exp=deada5ef", rd); end
        access(1'b0, 2'b01, 32'h12, 32'h0, rd, me, st, ok);
        checks++; if (rd !== 32'h0000DEAD) begin failures++; $display("FAIL lh_upper got=%h exp=0000dead", rd); end
        access(1'b0, 2'b10, 32'h13, 32'h0, rd, me, st, ok);
        checks++; if (rd !== 32'h000000DE) begin failures++; $display("FAIL lb_byte3 got=%h exp=000000de", rd); end
        access(1'b1, 2'b01, 32'h10, 32'h00001234, rd, me, st, ok);
        checks++; if (rd !== 32'h000000DE) begin failures++; $display("FAIL sh_rdata_kept got=%h exp=000000de", rd); end
        access(1'b0, 2'b00, 32'h10, 32'h0, rd, me, st, ok);
        checks++; if (rd !== 32'hDEAD1234) begin failures++; $display("FAIL sh_then_lw got=%h exp=dead1234", rd); end
`ifdef DMEM_ACCESS_COUNT_EN
        checks++; if (bus.LoadCount !== 16'd5) begin failures++; $display("FAIL load_count got=%0d exp=5", bus.LoadCount); end
        checks++; if (bus.StoreCount !== 16'd3) begin failures++; $display("FAIL store_count got=%0d exp=3", bus.StoreCount); end
`endif
    endtask

    task automatic test_misalign;
        logic [31:0] rd; logic me; int st; logic ok;
        access(1'b0, 2'b00, 32'h13, 32'h0, rd, me, st, ok);
        checks++; if (st != 3) begin failures++; $display("FAIL mis_lw_stall got=%0d exp=3", st); end
        checks++; if (me !== 1'b1 || ok !== 1'b1) begin failures++; $display("FAIL mis_lw_merr got=%b/%b exp=1/1", me, ok); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL mis_lw_rdata got=%h exp=00000000", rd); end
        access(1'b0, 2'b00, 32'h10, 32'h0, rd, me, st, ok);
        access(1'b1, 2'b01, 32'h11, 32'h0000BEEF, rd, me, st, ok);
        checks++; if (me !== 1'b1) begin failures++; $display("FAIL mis_sh_merr got=%b exp=1", me); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL mis_sh_rdata got=%h exp=00000000", rd); end
        access(1'b0, 2'b00, 32'h10, 32'h0, rd, me, st, ok);
        checks++; if (rd !== 32'hDEAD1234) begin failures++; $display("FAIL mis_word_unchanged got=%h exp=dead1234", rd); end
        checks++; if (me !== 1'b0) begin failures++; $display("FAIL aligned_merr got=%b exp=0", me); end
`ifdef DMEM_ACCESS_COUNT_EN
        checks++; if (bus.LoadCount !== 16'd7) begin failures++; $display("FAIL load_count_mis got=%0d exp=7", bus.LoadCount); end
        checks++; if (bus.StoreCount !== 16'd3) begin failures++; $display("FAIL store_count_mis got=%0d exp=3", bus.StoreCount); end
`endif
    endtask

    task automatic test_reset_busy;
        logic [31:0] rd; logic me; int st; logic ok;
        access(1'b1, 2'b00, 32'h20, 32'h22222222, rd, me, st, ok);
        @(negedge Clk);
        bus.MemWrite = 1'b1;
        bus.Size = 2'b00;
        bus.Address = 32'h20;
        bus.WriteData = 32'h11111111;
        @(posedge Clk);
        #1 bus.MemWrite = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        checks++; if (bus.Stall !== 1'b0) begin failures++; $display("FAIL rst_busy_stall got=%b exp=0", bus.Stall); end
        checks++; if (bus.Ready !== 1'b0) begin failures++; $display("FAIL rst_busy_ready got=%b exp=0", bus.Ready); end
        checks++; if (2'(dut.state_q) !== 2'd0) begin failures++; $display("FAIL rst_busy_state got=%0d exp=0", dut.state_q); end
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        access(1'b0, 2'b00, 32'h20, 32'h0, rd, me, st, ok);
        checks++; if (rd !== 32'h22222222) begin failures++; $display("FAIL rst_busy_no_commit got=%h exp=22222222", rd); end
    endtask

    task automatic test_wrap;
        logic [31:0] rd; logic me; int st; logic ok;
        access(1'b1, 2'b00, 32'd4096, 32'hCAFEF00D, rd, me, st, ok);
        access(1'b0, 2'b00, 32'h0, 32'h0, rd, me, st, ok);
        checks++; if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL wrap_lw got=%h exp=cafef00d", rd); end
        access(1'b0, 2'b10, 32'hFFFF_F003, 32'h0, rd, me, st, ok);
        checks++; if (rd !== 32'h000000CA) begin failures++; $display("FAIL wrap_lb_high got=%h exp=000000ca", rd); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset;
        test_word;
        test_lanes;
        test_misalign;
        test_reset_busy;
        test_wrap;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
